// File: rtl/jtframe_inputs_pkg.sv
// Shared constants and coin-channel state type for the jtframe_inputs conditioner.
package jtframe_inputs_pkg;

  localparam int CNTW  = 4;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int FIRE1 = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } coin_st_e;

endpackage

// File: rtl/jtframe_coin_ch.sv
// One coin channel: edge detect on the synced coin, IDLE/ACTIVE/HOLD FSM and
// a frame counter that stretches a press into a COIN_LEN-frame pulse.
module jtframe_coin_ch
  import jtframe_inputs_pkg::*;
#(
  parameter int COIN_LEN = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic coin_s,
  input  logic tick_s,
  output logic active_o,
  output logic accept_o
);

  coin_st_e        st_q, st_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            prev_q, prev_d;

  // Next-state logic; edges outside IDLE are ignored so one press is one pulse.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    prev_d   = coin_s;
    accept_o = 1'b0;
    case (st_q)
      IDLE: begin
        if (coin_s && !prev_q) begin
          st_d     = ACTIVE;
          cnt_d    = CNTW'(COIN_LEN);
          accept_o = 1'b1;
        end else begin
          st_d = IDLE;
        end
      end
      ACTIVE: begin
        if (tick_s) begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            st_d = HOLD;
          end else begin
            st_d = ACTIVE;
          end
        end else begin
          st_d = ACTIVE;
        end
      end
      HOLD: begin
        if (!coin_s) begin
          st_d = IDLE;
        end else begin
          st_d = HOLD;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = {CNTW{1'b0}};
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= {CNTW{1'b0}};
      prev_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  assign active_o = (st_q == ACTIVE);

endmodule

// File: rtl/jtframe_inputs.sv
// Cabinet-input conditioner: synchronisers, SOCD cleaning, frame-timed coins,
// pause toggle and coin meter. Optional autofire on fire 1 with JTFRAME_AUTOFIRE_EN.
module jtframe_inputs
  import jtframe_inputs_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int JOYW        = 10,
  parameter int COIN_LEN    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1
`ifdef JTFRAME_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV = 3
`endif
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    LVBL,
  input  logic [PLAYERS*JOYW-1:0] joy_in,
  input  logic [PLAYERS-1:0]      coin_in,
  input  logic [PLAYERS-1:0]      start_in,
  input  logic                    pause_btn,
  input  logic                    osd_pause,
  output logic [PLAYERS*JOYW-1:0] game_joystick,
  output logic [PLAYERS-1:0]      game_coin,
  output logic [PLAYERS-1:0]      game_start,
  output logic                    game_pause,
  output logic                    coin_cnt
);

  localparam int   JW   = PLAYERS * JOYW;
  localparam int   RAWW = JW + 2 * PLAYERS + 3;
  localparam logic INV  = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0][RAWW-1:0] sync_q, sync_d;
  logic [JW-1:0]      joy_s, joy_socd_s, joy_final_s, af_clr_s;
  logic [PLAYERS-1:0] coin_s, start_s, coin_act_s, coin_acc_s;
  logic               lvbl_s, pbtn_s, osd_s, tick_s, start_edge_s;

  logic               lvbl_prev_q, lvbl_prev_d;
  logic               pbtn_prev_q, pbtn_prev_d;
  logic [PLAYERS-1:0] start_prev_q, start_prev_d;
  logic               pause_q, pause_d;
  logic [JW-1:0]      game_joystick_q, game_joystick_d;
  logic [PLAYERS-1:0] game_coin_q, game_coin_d;
  logic [PLAYERS-1:0] game_start_q, game_start_d;
  logic               game_pause_q, game_pause_d;
  logic               coin_cnt_q, coin_cnt_d;

  // Every raw input travels through the same synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {osd_pause, pause_btn, LVBL, start_in, coin_in, joy_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign {osd_s, pbtn_s, lvbl_s, start_s, coin_s, joy_s} = sync_q[SYNC_STAGES-1];
  assign tick_s = lvbl_prev_q & ~lvbl_s;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    if (JOYW >= 4) begin : g_socd
      logic [JOYW-1:0] js;
      assign js = joy_s[p*JOYW +: JOYW];
      assign joy_socd_s[p*JOYW+UP]    = js[UP]    & ~js[DOWN];
      assign joy_socd_s[p*JOYW+DOWN]  = js[DOWN]  & ~js[UP];
      assign joy_socd_s[p*JOYW+LEFT]  = js[LEFT]  & ~js[RIGHT];
      assign joy_socd_s[p*JOYW+RIGHT] = js[RIGHT] & ~js[LEFT];
      if (JOYW > 4) begin : g_btn
        assign joy_socd_s[p*JOYW+4 +: JOYW-4] = js[JOYW-1:4];
      end
    end else begin : g_pass
      assign joy_socd_s[p*JOYW +: JOYW] = joy_s[p*JOYW +: JOYW];
    end

    jtframe_coin_ch #(
      .COIN_LEN (COIN_LEN)
    ) u_coin (
      .clk      (clk),
      .rst      (rst),
      .coin_s   (coin_s[p]),
      .tick_s   (tick_s),
      .active_o (coin_act_s[p]),
      .accept_o (coin_acc_s[p])
    );
  end

`ifdef JTFRAME_AUTOFIRE_EN
  if (JOYW > FIRE1) begin : g_af
    logic [PLAYERS-1:0][CNTW-1:0] hold_q, hold_d;
    logic [PLAYERS-1:0][7:0]      div_q, div_d;
    logic [PLAYERS-1:0]           af_q, af_d;

    // Autofire starts after 9 held frames, then toggles every AUTOFIRE_DIV ticks.
    always_comb begin
      hold_d   = hold_q;
      div_d    = div_q;
      af_d     = af_q;
      af_clr_s = {JW{1'b0}};
      for (int p = 0; p < PLAYERS; p++) begin
        if (!joy_socd_s[p*JOYW+FIRE1]) begin
          hold_d[p] = {CNTW{1'b0}};
          div_d[p]  = 8'd0;
          af_d[p]   = 1'b0;
        end else if (tick_s) begin
          if (hold_q[p] < CNTW'(9)) begin
            hold_d[p] = hold_q[p] + CNTW'(1);
          end else if (div_q[p] >= 8'(AUTOFIRE_DIV - 1)) begin
            div_d[p] = 8'd0;
            af_d[p]  = ~af_q[p];
          end else begin
            div_d[p] = div_q[p] + 8'd1;
          end
        end else begin
          hold_d[p] = hold_q[p];
        end
        af_clr_s[p*JOYW+FIRE1] = af_q[p] & joy_socd_s[p*JOYW+FIRE1];
      end
    end

    // Autofire counters.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
        div_q  <= '0;
        af_q   <= {PLAYERS{1'b0}};
      end else begin
        hold_q <= hold_d;
        div_q  <= div_d;
        af_q   <= af_d;
      end
    end
  end else begin : g_no_af
    assign af_clr_s = {JW{1'b0}};
  end
`else
  assign af_clr_s = {JW{1'b0}};
`endif

  assign joy_final_s = joy_socd_s & ~af_clr_s;

  // Pause toggle, edge trackers and output formatting.
  always_comb begin
    lvbl_prev_d  = lvbl_s;
    pbtn_prev_d  = pbtn_s;
    start_prev_d = start_s;
    start_edge_s = |(start_s & ~start_prev_q);
    if (pbtn_s && !pbtn_prev_q) begin
      pause_d = ~pause_q;
    end else if (start_edge_s) begin
      pause_d = 1'b0;
    end else begin
      pause_d = pause_q;
    end
    game_pause_d    = pause_d | osd_s;
    game_joystick_d = joy_final_s ^ {JW{INV}};
    game_coin_d     = coin_act_s ^ {PLAYERS{INV}};
    game_start_d    = start_s ^ {PLAYERS{INV}};
    coin_cnt_d      = |coin_acc_s;
  end

  // Synchronisers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q          <= '0;
      lvbl_prev_q     <= 1'b0;
      pbtn_prev_q     <= 1'b0;
      start_prev_q    <= {PLAYERS{1'b0}};
      pause_q         <= 1'b0;
      game_joystick_q <= {JW{INV}};
      game_coin_q     <= {PLAYERS{INV}};
      game_start_q    <= {PLAYERS{INV}};
      game_pause_q    <= 1'b0;
      coin_cnt_q      <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      lvbl_prev_q     <= lvbl_prev_d;
      pbtn_prev_q     <= pbtn_prev_d;
      start_prev_q    <= start_prev_d;
      pause_q         <= pause_d;
      game_joystick_q <= game_joystick_d;
      game_coin_q     <= game_coin_d;
      game_start_q    <= game_start_d;
      game_pause_q    <= game_pause_d;
      coin_cnt_q      <= coin_cnt_d;
    end
  end

  assign game_joystick = game_joystick_q;
  assign game_coin     = game_coin_q;
  assign game_start    = game_start_q;
  assign game_pause    = game_pause_q;
  assign coin_cnt      = coin_cnt_q;

endmodule

// File: tb/tb_jtframe_inputs.sv
// Self-checking bench for jtframe_inputs: directed steps plus random stimulus,
// compared every cycle against a latency-aware behavioural model.
module tb_jtframe_inputs;

  localparam int PLAYERS     = 2;
  localparam int JOYW        = 10;
  localparam int COIN_LEN    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int ACTIVE_LOW  = 1;
  localparam int JW          = PLAYERS * JOYW;
  localparam int FR          = 12;
  localparam int S           = SYNC_STAGES;

  logic               clk, rst, LVBL, pause_btn, osd_pause;
  logic [JW-1:0]      joy_in;
  logic [PLAYERS-1:0] coin_in, start_in;
  logic [JW-1:0]      game_joystick;
  logic [PLAYERS-1:0] game_coin, game_start;
  logic               game_pause, coin_cnt;

  typedef struct packed {
    logic [JW-1:0]      joy;
    logic [PLAYERS-1:0] coin;
    logic [PLAYERS-1:0] start;
    logic               lvbl;
    logic               pbtn;
    logic               osd;
  } raw_t;

  raw_t               ring [16];
  int                 cyc, fpos, checks, errs, n_cnt, n_low;
  int                 left [PLAYERS];
  bit                 waitlow [PLAYERS];
  bit                 m_pause;
  logic [JW-1:0]      e_joy;
  logic [PLAYERS-1:0] e_coin, e_start;
  logic               e_pause, e_cnt;

  jtframe_inputs #(
    .PLAYERS     (PLAYERS),
    .JOYW        (JOYW),
    .COIN_LEN    (COIN_LEN),
    .SYNC_STAGES (SYNC_STAGES),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .LVBL          (LVBL),
    .joy_in        (joy_in),
    .coin_in       (coin_in),
    .start_in      (start_in),
    .pause_btn     (pause_btn),
    .osd_pause     (osd_pause),
    .game_joystick (game_joystick),
    .game_coin     (game_coin),
    .game_start    (game_start),
    .game_pause    (game_pause),
    .coin_cnt      (coin_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [JW-1:0] clean(input logic [JW-1:0] j);
    logic [JW-1:0]   r;
    logic [JOYW-1:0] s;
    r = j;
    for (int p = 0; p < PLAYERS; p++) begin
      s = j[p*JOYW +: JOYW];
      if (s[0] && s[1]) begin s[0] = 1'b0; s[1] = 1'b0; end
      if (s[2] && s[3]) begin s[2] = 1'b0; s[3] = 1'b0; end
      r[p*JOYW +: JOYW] = s;
    end
    return r;
  endfunction

  function automatic raw_t at(input int k);
    if (k < 1) return '0;
    return ring[k % 16];
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 16; i++) ring[i] = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      left[p]    = 0;
      waitlow[p] = 1'b0;
    end
    m_pause = 1'b0;
  endtask

  // Inputs reach the logic S cycles after they are applied; outputs are one register later.
  task automatic model_step();
    raw_t syn, prv;
    bit   tick;
    cyc++;
    ring[cyc % 16] = {joy_in, coin_in, start_in, LVBL, pause_btn, osd_pause};
    syn  = at(cyc - S);
    prv  = at(cyc - S - 1);
    tick = prv.lvbl && !syn.lvbl;
    e_joy   = ~clean(syn.joy);
    e_start = ~syn.start;
    e_cnt   = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      e_coin[p] = (left[p] > 0) ? 1'b0 : 1'b1;
      if (left[p] > 0) begin
        if (tick) begin
          left[p]--;
          if (left[p] == 0) waitlow[p] = 1'b1;
        end
      end else if (waitlow[p]) begin
        if (!syn.coin[p]) waitlow[p] = 1'b0;
      end else if (syn.coin[p] && !prv.coin[p]) begin
        left[p] = COIN_LEN;
        e_cnt   = 1'b1;
      end
    end
    if (syn.pbtn && !prv.pbtn) m_pause = !m_pause;
    else if ((syn.start & ~prv.start) != '0) m_pause = 1'b0;
    e_pause = m_pause | syn.osd;
  endtask

  task automatic step();
    LVBL = (fpos >= 3);
    fpos = (fpos + 1) % FR;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    if (!rst) begin
      chk("joystick", 32'(game_joystick), 32'(e_joy));
      chk("coin", 32'(game_coin), 32'(e_coin));
      chk("start", 32'(game_start), 32'(e_start));
      chk("pause", 32'(game_pause), 32'(e_pause));
      chk("coin_cnt", 32'(coin_cnt), 32'(e_cnt));
    end
  endtask

  initial begin
    checks = 0; errs = 0; fpos = 0;
    rst = 1'b1; LVBL = 1'b0; pause_btn = 1'b0; osd_pause = 1'b0;
    joy_in = '0; coin_in = '0; start_in = '0;
    model_reset();
    repeat (3) step();
    chk("rst_joystick", 32'(game_joystick), 32'h000F_FFFF);
    chk("rst_coin", 32'(game_coin), 32'h3);
    chk("rst_start", 32'(game_start), 32'h3);
    chk("rst_pause", 32'(game_pause), 32'h0);
    chk("rst_coin_cnt", 32'(coin_cnt), 32'h0);
    rst = 1'b0;

    // SOCD cleaning and latency
    joy_in[3:0] = 4'b0001;
    repeat (S + 1) step();
    chk("socd_up_only", 32'(game_joystick[3:0]), 32'hE);
    joy_in[3:0] = 4'b0011;
    repeat (S) step();
    chk("socd_latency_hold", 32'(game_joystick[3:0]), 32'hE);
    step();
    chk("socd_up_down", 32'(game_joystick[3:0]), 32'hF);
    joy_in[3:0] = 4'b0101;
    repeat (S + 1) step();
    chk("socd_up_left", 32'(game_joystick[3:0]), 32'hA);
    joy_in[13:10] = 4'b1111;
    joy_in[3:0]   = 4'b1100;
    repeat (S + 1) step();
    chk("socd_p1_all", 32'(game_joystick[13:10]), 32'hF);
    chk("socd_left_right", 32'(game_joystick[3:0]), 32'hF);

    // One-clock coin on player 1, with re-presses inside the pulse
    coin_in[1] = 1'b1;
    step();
    coin_in[1] = 1'b0;
    n_cnt = 0; n_low = 0;
    for (int i = 0; i < 6 * FR; i++) begin
      coin_in[1] = (i == 12 || i == 24);
      step();
      n_cnt += int'(coin_cnt);
      n_low += int'(!game_coin[1]);
    end
    chk("coin1_pulses", 32'(n_cnt), 32'd1);
    chk("coin1_len", 32'(n_low >= 3 * FR + 1 && n_low <= 4 * FR), 32'd1);

    // Coin held across 10 frames, then pressed again
    coin_in[0] = 1'b1;
    n_cnt = 0; n_low = 0;
    for (int i = 0; i < 10 * FR; i++) begin
      step();
      n_cnt += int'(coin_cnt);
      n_low += int'(!game_coin[0]);
    end
    coin_in[0] = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      n_cnt += int'(coin_cnt);
      n_low += int'(!game_coin[0]);
    end
    chk("coin0_held_pulses", 32'(n_cnt), 32'd1);
    chk("coin0_held_len", 32'(n_low >= 3 * FR + 1 && n_low <= 4 * FR), 32'd1);
    coin_in[0] = 1'b1;
    for (int i = 0; i < 6 * FR; i++) begin
      step();
      n_cnt += int'(coin_cnt);
    end
    coin_in[0] = 1'b0;
    repeat (2) step();
    chk("coin0_repress", 32'(n_cnt), 32'd2);

    // Pause toggle, start resume, OSD override
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    repeat (3) step();
    chk("pause_on", 32'(game_pause), 32'd1);
    start_in[0] = 1'b1;
    step();
    start_in[0] = 1'b0;
    repeat (3) step();
    chk("pause_start_resume", 32'(game_pause), 32'd0);
    osd_pause = 1'b1;
    repeat (S + 1) step();
    chk("pause_osd", 32'(game_pause), 32'd1);
    osd_pause = 1'b0;
    repeat (S + 1) step();
    chk("pause_osd_off", 32'(game_pause), 32'd0);

    // Reset in the middle of a coin pulse
    coin_in[1] = 1'b1;
    step();
    coin_in[1] = 1'b0;
    repeat (2 * FR) step();
    chk("coin_mid_pulse", 32'(game_coin[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_coin", 32'(game_coin), 32'h3);
    chk("midrst_joystick", 32'(game_joystick), 32'h000F_FFFF);
    chk("midrst_coin_cnt", 32'(coin_cnt), 32'h0);
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    n_cnt = 0; n_low = 0;
    repeat (5 * FR) begin
      step();
      n_cnt += int'(coin_cnt);
      n_low += int'(game_coin != 2'b11);
    end
    chk("post_rst_no_count", 32'(n_cnt), 32'd0);
    chk("post_rst_no_pulse", 32'(n_low), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      joy_in = JW'($urandom);
      for (int p = 0; p < PLAYERS; p++) begin
        if ($urandom_range(0, 15) == 0) coin_in[p] = ~coin_in[p];
        if ($urandom_range(0, 39) == 0) start_in[p] = ~start_in[p];
      end
      if ($urandom_range(0, 24) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 59) == 0) osd_pause = ~osd_pause;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
